// File: rtl/vga_sram_pkg.sv
// Shared types and constants for the VGA asynchronous SRAM controller.
package vga_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  localparam int WAIT_W = 3;

  // Inactive (deasserted) levels of the active-low SRAM strobes
  localparam logic       CE_OFF = 1'b1;
  localparam logic       OE_OFF = 1'b1;
  localparam logic       WE_OFF = 1'b1;
  localparam logic [1:0] BW_OFF = 2'b11;

endpackage

// File: rtl/vga_sram_pad.sv
// Tri-state wrapper for the 16-bit SRAM data bus, keeping the inout out of the FSM.
module vga_sram_pad (
  inout  wire  [15:0] data_io,
  input  logic        oe,
  input  logic [15:0] dout,
  output logic [15:0] din
);

  assign data_io = oe ? dout : 16'hzzzz;
  assign din     = data_io;

endmodule

// File: rtl/vga_sram_ctrl.sv
// Strobe/ack master port to asynchronous 16-bit SRAM sequencer with wait states.
// Optional one-word read cache enabled by defining VGA_SRAM_READ_CACHE_EN.
module vga_sram_ctrl
  import vga_sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [16:0] csrm_adr_i,
  input  logic [1:0]  csrm_sel_i,
  input  logic        csrm_we_i,
  input  logic [15:0] csrm_dat_i,
  input  logic        csrm_stb_i,
  output logic [15:0] csrm_dat_o,
  output logic        csrm_ack_o,
  output logic [16:0] sram_addr_o,
  inout  wire  [15:0] sram_data_io,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic [1:0]  sram_bw_n_o
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

  state_e            state_r, state_nxt_s;
  logic [WAIT_W-1:0] cnt_r;
  logic [16:0]       adr_r, req_adr_s, addr_r, addr_nxt_s;
  logic [1:0]        sel_r, req_sel_s, bw_n_r, bw_n_nxt_s;
  logic              we_r, req_we_s;
  logic [15:0]       dat_r, req_dat_s, bus_dat_r, bus_dat_nxt_s, rd_dat_r, din_s;
  logic              ce_n_r, ce_n_nxt_s, oe_n_r, oe_n_nxt_s, we_n_r, we_n_nxt_s;
  logic              bus_en_r, bus_en_nxt_s, ack_r, ack_nxt_s;
  logic              start_s, capture_s, hit_s;

  assign start_s   = (state_r == ST_IDLE) && csrm_stb_i;
  assign capture_s = (state_r == ST_ACCESS) && (state_nxt_s == ST_ACK);

  // Pins for SETUP are registered at the sample edge, so use live inputs while idle
  assign req_adr_s = (state_r == ST_IDLE) ? csrm_adr_i : adr_r;
  assign req_sel_s = (state_r == ST_IDLE) ? csrm_sel_i : sel_r;
  assign req_we_s  = (state_r == ST_IDLE) ? csrm_we_i  : we_r;
  assign req_dat_s = (state_r == ST_IDLE) ? csrm_dat_i : dat_r;

`ifdef VGA_SRAM_READ_CACHE_EN
  logic        cache_vld_r;
  logic [16:0] cache_tag_r;
  logic [15:0] cache_dat_r;

  assign hit_s = cache_vld_r && !csrm_we_i && (csrm_adr_i == cache_tag_r);

  // One-word read cache: any write invalidates, completed SRAM reads refill
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cache_vld_r <= 1'b0;
      cache_tag_r <= 17'h00000;
      cache_dat_r <= 16'h0000;
    end else if (start_s && csrm_we_i) begin
      cache_vld_r <= 1'b0;
    end else if (capture_s) begin
      cache_vld_r <= 1'b1;
      cache_tag_r <= adr_r;
      cache_dat_r <= din_s;
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // Next state and the pin levels that state will present once registered
  always_comb begin
    state_nxt_s   = state_r;
    addr_nxt_s    = addr_r;
    bus_dat_nxt_s = bus_dat_r;
    ce_n_nxt_s    = CE_OFF;
    oe_n_nxt_s    = OE_OFF;
    we_n_nxt_s    = WE_OFF;
    bw_n_nxt_s    = BW_OFF;
    bus_en_nxt_s  = 1'b0;
    ack_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE:   if (csrm_stb_i) state_nxt_s = hit_s ? ST_ACK : ST_SETUP;
                 else            state_nxt_s = ST_IDLE;
      ST_SETUP:  state_nxt_s = ST_ACCESS;
      ST_ACCESS: if (cnt_r == 3'd0) state_nxt_s = we_r ? ST_HOLD : ST_ACK;
                 else               state_nxt_s = ST_ACCESS;
      ST_HOLD:   state_nxt_s = ST_ACK;
      ST_ACK:    state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
    case (state_nxt_s)
      ST_SETUP, ST_ACCESS, ST_HOLD: begin
        addr_nxt_s = req_adr_s;
        ce_n_nxt_s = 1'b0;
        if (req_we_s) begin
          bw_n_nxt_s    = ~req_sel_s;
          bus_en_nxt_s  = 1'b1;
          bus_dat_nxt_s = req_dat_s;
          we_n_nxt_s    = (state_nxt_s == ST_ACCESS) ? 1'b0 : WE_OFF;
        end else begin
          oe_n_nxt_s = 1'b0;
          bw_n_nxt_s = 2'b00;
        end
      end
      ST_ACK:  ack_nxt_s = 1'b1;
      default: ack_nxt_s = 1'b0;
    endcase
  end

  // FSM, wait counter, request latch and registered pins
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 3'd0;
      adr_r     <= 17'h00000;
      sel_r     <= 2'b00;
      we_r      <= 1'b0;
      dat_r     <= 16'h0000;
      addr_r    <= 17'h00000;
      bus_dat_r <= 16'h0000;
      ce_n_r    <= CE_OFF;
      oe_n_r    <= OE_OFF;
      we_n_r    <= WE_OFF;
      bw_n_r    <= BW_OFF;
      bus_en_r  <= 1'b0;
      ack_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_SETUP)  cnt_r <= WAIT_LD;
      else if (cnt_r != 3'd0)   cnt_r <= cnt_r - 3'd1;
      if (start_s) begin
        adr_r <= csrm_adr_i;
        sel_r <= csrm_sel_i;
        we_r  <= csrm_we_i;
        dat_r <= csrm_dat_i;
      end
      addr_r    <= addr_nxt_s;
      bus_dat_r <= bus_dat_nxt_s;
      ce_n_r    <= ce_n_nxt_s;
      oe_n_r    <= oe_n_nxt_s;
      we_n_r    <= we_n_nxt_s;
      bw_n_r    <= bw_n_nxt_s;
      bus_en_r  <= bus_en_nxt_s;
      ack_r     <= ack_nxt_s;
    end
  end

  // Read data register; writes leave it untouched
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rd_dat_r <= 16'h0000;
    end else if (capture_s) begin
      rd_dat_r <= din_s;
`ifdef VGA_SRAM_READ_CACHE_EN
    end else if (start_s && hit_s) begin
      rd_dat_r <= cache_dat_r;
`endif
    end
  end

  vga_sram_pad u_pad (
    .data_io (sram_data_io),
    .oe      (bus_en_r),
    .dout    (bus_dat_r),
    .din     (din_s)
  );

  assign csrm_dat_o  = rd_dat_r;
  assign csrm_ack_o  = ack_r;
  assign sram_addr_o = addr_r;
  assign sram_ce_n_o = ce_n_r;
  assign sram_oe_n_o = oe_n_r;
  assign sram_we_n_o = we_n_r;
  assign sram_bw_n_o = bw_n_r;

endmodule

// File: tb/tb_vga_sram_ctrl.sv
// Directed bench for vga_sram_ctrl with WAIT_CYCLES 1, 0 and 7 and a behavioural SRAM.
module tb_vga_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] adr;
  logic [1:0]  sel;
  logic        we;
  logic [15:0] dat;
  logic        stb1, stb0, stb7;

  logic [15:0] dat1, dat0, dat7;
  logic        ack1, ack0, ack7;
  logic [16:0] addr1, addr0, addr7;
  logic        ce1, oe1, wen1, ce0, oe0, wen0, ce7, oe7, wen7;
  logic [1:0]  bw1, bw0, bw7;
  wire  [15:0] bus1, bus0, bus7;

  int n_vec = 0;
  int n_err = 0;
  int contention = 0;
  int lat, ce_c, oe_c, we_c, drv_c, l0, l7;
  logic [1:0]  bw_f;
  logic [15:0] bus_h, rd, d0, d7;

  always #5 clk = ~clk;

  vga_sram_ctrl #(.WAIT_CYCLES(1)) u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .csrm_adr_i(adr), .csrm_sel_i(sel),
    .csrm_we_i(we), .csrm_dat_i(dat), .csrm_stb_i(stb1), .csrm_dat_o(dat1),
    .csrm_ack_o(ack1), .sram_addr_o(addr1), .sram_data_io(bus1),
    .sram_ce_n_o(ce1), .sram_oe_n_o(oe1), .sram_we_n_o(wen1), .sram_bw_n_o(bw1));

  vga_sram_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .csrm_adr_i(adr), .csrm_sel_i(sel),
    .csrm_we_i(we), .csrm_dat_i(dat), .csrm_stb_i(stb0), .csrm_dat_o(dat0),
    .csrm_ack_o(ack0), .sram_addr_o(addr0), .sram_data_io(bus0),
    .sram_ce_n_o(ce0), .sram_oe_n_o(oe0), .sram_we_n_o(wen0), .sram_bw_n_o(bw0));

  vga_sram_ctrl #(.WAIT_CYCLES(7)) u_dut7 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .csrm_adr_i(adr), .csrm_sel_i(sel),
    .csrm_we_i(we), .csrm_dat_i(dat), .csrm_stb_i(stb7), .csrm_dat_o(dat7),
    .csrm_ack_o(ack7), .sram_addr_o(addr7), .sram_data_io(bus7),
    .sram_ce_n_o(ce7), .sram_oe_n_o(oe7), .sram_we_n_o(wen7), .sram_bw_n_o(bw7));

  // Behavioural SRAM for the main instance
  logic [15:0] mem [0:131071];
  logic        preloaded = 1'b0;
  logic        model_drv;
  assign model_drv = !ce1 && !oe1 && wen1;
  assign bus1 = model_drv ? mem[addr1] : 16'hzzzz;

  always @(posedge clk) begin
    if (!preloaded) begin
      mem[17'h00123] <= 16'hA55A;
      mem[17'h1FFFF] <= 16'h5678;
      mem[17'h00040] <= 16'hBEEF;
      mem[17'h00041] <= 16'h0000;
      preloaded      <= 1'b1;
    end else if (!ce1 && !wen1) begin
      if (!bw1[1]) mem[addr1][15:8] <= bus1[15:8];
      if (!bw1[0]) mem[addr1][7:0]  <= bus1[7:0];
    end
  end

  always @(negedge clk)
    if (model_drv && u_dut.bus_en_r) contention <= contention + 1;

  assign bus0 = (!ce0 && !oe0) ? 16'hC3C3 : 16'hzzzz;
  assign bus7 = (!ce7 && !oe7) ? 16'h3C3C : 16'hzzzz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request on the main instance and watch the pins until ack (bounded)
  task automatic do_req(input logic w, input logic [16:0] a, input logic [1:0] s,
                        input logic [15:0] d);
    adr = a; we = w; sel = s; dat = d; stb1 = 1'b1;
    lat = 0; ce_c = 0; oe_c = 0; we_c = 0; drv_c = 0; bw_f = 2'b11; bus_h = 16'h0000;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!ce1) begin
        if (ce_c == 0) bw_f = bw1;
        ce_c++;
      end
      if (!oe1)  oe_c++;
      if (!wen1) we_c++;
      if (u_dut.bus_en_r) begin
        drv_c++;
        bus_h = bus1;
      end
    end while (!ack1 && lat < 30);
    rd = dat1;
  endtask

  initial begin
    rst_n = 1'b0; stb1 = 1'b0; stb0 = 1'b0; stb7 = 1'b0;
    adr = 17'h00000; sel = 2'b00; we = 1'b0; dat = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",  32'(ack1),  32'd0);
    chk("rst_dat",  32'(dat1),  32'h0);
    chk("rst_addr", 32'(addr1), 32'h0);
    chk("rst_ctrl", 32'({ce1, oe1, wen1, bw1}), 32'h1F);
    chk("rst_bus",  32'(u_dut.bus_en_r), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read, WAIT_CYCLES=1: latency 4 from the edge stb is presented at
    do_req(1'b0, 17'h00123, 2'b00, 16'h0000);
    chk("rd_lat",  32'(lat), 32'd4);
    chk("rd_dat",  32'(rd), 32'hA55A);
    chk("rd_oe",   32'(oe_c), 32'd3);
    chk("rd_we",   32'(we_c), 32'd0);
    chk("rd_drv",  32'(drv_c), 32'd0);
    chk("rd_bw",   32'(bw_f), 32'h0);
    stb1 = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", 32'(ack1), 32'd0);
    chk("dat_hold",  32'(dat1), 32'hA55A);

    // Write high byte to the top address, then a read with stb held across ack
    do_req(1'b1, 17'h1FFFF, 2'b10, 16'h1234);
    chk("wr_lat",  32'(lat), 32'd5);
    chk("wr_bw",   32'(bw_f), 32'h1);
    chk("wr_we",   32'(we_c), 32'd2);
    chk("wr_oe",   32'(oe_c), 32'd0);
    chk("wr_drv",  32'(drv_c), 32'd4);
    chk("wr_hold", 32'(bus_h), 32'h1234);
    chk("wr_dato", 32'(rd), 32'hA55A);
    @(posedge clk); #1;
    chk("idle_ce",  32'(ce1), 32'd1);
    chk("idle_bus", 32'(u_dut.bus_en_r), 32'd0);
    chk("wr_mem",   32'(mem[17'h1FFFF]), 32'h1278);
    do_req(1'b0, 17'h1FFFF, 2'b00, 16'h0000);
    chk("b2b_lat", 32'(lat), 32'd4);
    chk("b2b_dat", 32'(rd), 32'h1278);
    stb1 = 1'b0;
    @(posedge clk); #1;

    // Reset during the write's ACCESS phase
    adr = 17'h00200; we = 1'b1; sel = 2'b11; dat = 16'hDEAD; stb1 = 1'b1;
    for (int i = 0; i < 10 && wen1; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_pre_we", 32'(wen1), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we",  32'(wen1), 32'd1);
    chk("rst_mid_ce",  32'(ce1), 32'd1);
    chk("rst_mid_bus", 32'(u_dut.bus_en_r), 32'd0);
    chk("rst_mid_ack", 32'(ack1), 32'd0);
    stb1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_ack", 32'(ack1), 32'd0);
    chk("rst_dat0",   32'(dat1), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 17'h00123, 2'b00, 16'h0000);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_dat", 32'(rd), 32'hA55A);
    stb1 = 1'b0;
    @(posedge clk); #1;

    // WAIT_CYCLES=0 and 7 read latencies
    adr = 17'h00123; we = 1'b0; sel = 2'b00;
    stb0 = 1'b1; stb7 = 1'b1; l0 = 0; l7 = 0; d0 = 16'h0000; d7 = 16'h0000;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ack0 && l0 == 0) begin l0 = c; d0 = dat0; stb0 = 1'b0; end
      if (ack7 && l7 == 0) begin l7 = c; d7 = dat7; stb7 = 1'b0; end
    end
    stb0 = 1'b0; stb7 = 1'b0;
    chk("w0_lat", 32'(l0), 32'd3);
    chk("w7_lat", 32'(l7), 32'd10);
    chk("w0_dat", 32'(d0), 32'hC3C3);
    chk("w7_dat", 32'(d7), 32'h3C3C);

    // Repeated read of one address, then a write elsewhere, then the read again
    do_req(1'b0, 17'h00040, 2'b00, 16'h0000);
    chk("c1_lat", 32'(lat), 32'd4);
    chk("c1_dat", 32'(rd), 32'hBEEF);
    stb1 = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 17'h00040, 2'b00, 16'h0000);
`ifdef VGA_SRAM_READ_CACHE_EN
    chk("c2_lat", 32'(lat), 32'd1);
    chk("c2_ce",  32'(ce_c), 32'd0);
`else
    chk("c2_lat", 32'(lat), 32'd4);
    chk("c2_ce",  32'(ce_c), 32'd3);
`endif
    chk("c2_dat", 32'(rd), 32'hBEEF);
    stb1 = 1'b0;
    @(posedge clk); #1;
    do_req(1'b1, 17'h00041, 2'b11, 16'h0041);
    chk("c3_lat", 32'(lat), 32'd5);
    stb1 = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 17'h00040, 2'b00, 16'h0000);
    chk("c4_lat", 32'(lat), 32'd4);
    chk("c4_ce",  32'(ce_c), 32'd3);
    chk("c4_dat", 32'(rd), 32'hBEEF);
    stb1 = 1'b0;
    @(posedge clk); #1;

    chk("contention", 32'(contention), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
